// File: rtl/icap_cfg_reg_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : icap_cfg_reg_reader_if
// Description : Request/response handshake between a register front end and
//               the ICAP configuration register reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface icap_cfg_reg_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_reg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  // Requester side (register block or testbench)
  modport master (
    output req_valid, req_reg, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // Reader side
  modport slave (
    input  req_valid, req_reg, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/icap_cfg_reg_reader.sv
`default_nettype none
// ============================================================================
// Module      : icap_cfg_reg_reader
// Description : Reads one 32-bit configuration register through ICAPE3:
//               sync, Type-1 read header, read window, DESYNC, response.
// Revision    : 1.0 - initial release
// ============================================================================
module icap_cfg_reg_reader #(
  parameter int READ_WAIT = 8
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  icap_cfg_reg_reader_if.slave   bus,
  input  logic                   icap_avail,
  output logic                   icap_busy,
  output logic                   icap_csib,
  output logic                   icap_rdwrb,
  output logic [31:0]            icap_i,
  input  logic [31:0]            icap_o
);

  localparam logic [31:0] C_DUMMY      = 32'hFFFF_FFFF;
  localparam logic [31:0] C_SYNC       = 32'hAA99_5566;
  localparam logic [31:0] C_NOOP       = 32'h2000_0000;
  localparam logic [31:0] C_RD_HDR     = 32'h2800_0001;
  localparam logic [31:0] C_DESYNC_HDR = 32'h3000_8001;
  localparam logic [31:0] C_DESYNC_CMD = 32'h0000_000D;

  // Counter must cover both the 7-word header and the read window
  localparam int                CNT_MAX = (READ_WAIT > 7) ? READ_WAIT : 7;
  localparam int                CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  RD_LAST = CNT_W'(READ_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_HDR    = 3'd1,
    ST_TO_RD     = 3'd2,
    ST_RD_WAIT   = 3'd3,
    ST_TO_WR     = 3'd4,
    ST_WR_DESYNC = 3'd5,
    ST_RESP      = 3'd6
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        reg_q;
  logic              csib_q;
  logic              rdwrb_q;
  logic [31:0]       i_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;

  logic              w_req_ready;
  logic [2:0]        w_hdr_nxt;
  logic [1:0]        w_ds_nxt;

  // ICAP data lanes are bit-reversed within each byte
  function automatic logic [31:0] rev8(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        r[8*b + k] = w[8*b + 7 - k];
      end
    end
    return r;
  endfunction

  // Word idx of the sync + read-header preamble
  function automatic logic [31:0] hdr_word(input logic [2:0] idx, input logic [4:0] r);
    logic [31:0] w;
    case (idx)
      3'd0:    w = C_DUMMY;
      3'd1:    w = C_SYNC;
      3'd4:    w = C_RD_HDR | {14'd0, r, 13'd0};
      default: w = C_NOOP;
    endcase
    return w;
  endfunction

  // Word idx of the DESYNC postamble
  function automatic logic [31:0] desync_word(input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = C_DESYNC_HDR;
      2'd1:    w = C_DESYNC_CMD;
      default: w = C_NOOP;
    endcase
    return w;
  endfunction

  // Accept only when idle with no response pending and ICAP available
  assign w_req_ready = axi_aresetn && (state_q == ST_IDLE) && !rsp_valid_q && icap_avail;
  assign w_hdr_nxt   = cnt_q[2:0] + 3'd1;
  assign w_ds_nxt    = cnt_q[1:0] + 2'd1;

  // Sequencer: every ICAP pin and response output is registered here
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      reg_q       <= '0;
      csib_q      <= 1'b1;
      rdwrb_q     <= 1'b0;
      i_q         <= rev8(C_DUMMY);
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid && w_req_ready) begin
            state_q <= ST_WR_HDR;
            cnt_q   <= '0;
            reg_q   <= bus.req_reg;
            csib_q  <= 1'b0;
            rdwrb_q <= 1'b0;
            i_q     <= rev8(C_DUMMY);
            busy_q  <= 1'b1;
          end
        end
        ST_WR_HDR: begin
          if (cnt_q[2:0] == 3'd6) begin
            state_q <= ST_TO_RD;
            cnt_q   <= '0;
            csib_q  <= 1'b1;
            i_q     <= rev8(C_DUMMY);
          end else begin
            cnt_q <= cnt_q + 1'b1;
            i_q   <= rev8(hdr_word(w_hdr_nxt, reg_q));
          end
        end
        ST_TO_RD: begin
          // Direction flips only while CSIB is deasserted
          if (cnt_q == '0) begin
            cnt_q   <= cnt_q + 1'b1;
            rdwrb_q <= 1'b1;
          end else begin
            state_q <= ST_RD_WAIT;
            cnt_q   <= '0;
            csib_q  <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          if (cnt_q == RD_LAST) begin
            state_q    <= ST_TO_WR;
            cnt_q      <= '0;
            csib_q     <= 1'b1;
            rsp_data_q <= rev8(icap_o);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_TO_WR: begin
          if (cnt_q == '0) begin
            cnt_q   <= cnt_q + 1'b1;
            rdwrb_q <= 1'b0;
          end else begin
            state_q <= ST_WR_DESYNC;
            cnt_q   <= '0;
            csib_q  <= 1'b0;
            i_q     <= rev8(C_DESYNC_HDR);
          end
        end
        ST_WR_DESYNC: begin
          if (cnt_q[1:0] == 2'd3) begin
            state_q     <= ST_RESP;
            cnt_q       <= '0;
            csib_q      <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            i_q         <= rev8(C_DUMMY);
          end else begin
            cnt_q <= cnt_q + 1'b1;
            i_q   <= rev8(desync_word(w_ds_nxt));
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign icap_busy     = busy_q;
  assign icap_csib     = csib_q;
  assign icap_rdwrb    = rdwrb_q;
  assign icap_i        = i_q;

endmodule
`default_nettype wire

// File: tb/tb_icap_cfg_reg_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_icap_cfg_reg_reader
// Description : Self-checking bench for icap_cfg_reg_reader with READ_WAIT=8
//               and READ_WAIT=2 instances and a cycle-accurate ICAP model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icap_cfg_reg_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        req_valid;
  logic        rsp_ready;
  logic        avail;
  logic        dsel;
  logic [4:0]  req_reg;
  logic [31:0] mval;

  logic        busy8, csib8, rdwrb8, busy2, csib2, rdwrb2;
  logic [31:0] ii8, io8, ii2, io2;
  int          rdcnt8 = 0;
  int          rdcnt2 = 0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  icap_cfg_reg_reader_if bus8();
  icap_cfg_reg_reader_if bus2();

  assign bus8.req_valid = req_valid && !dsel;
  assign bus2.req_valid = req_valid && dsel;
  assign bus8.req_reg   = req_reg;
  assign bus2.req_reg   = req_reg;
  assign bus8.rsp_ready = rsp_ready;
  assign bus2.rsp_ready = rsp_ready;

  icap_cfg_reg_reader #(.READ_WAIT(8)) u_dut8 (
    .axi_aclk(clk), .axi_aresetn(rstn), .bus(bus8), .icap_avail(avail),
    .icap_busy(busy8), .icap_csib(csib8), .icap_rdwrb(rdwrb8),
    .icap_i(ii8), .icap_o(io8)
  );

  icap_cfg_reg_reader #(.READ_WAIT(2)) u_dut2 (
    .axi_aclk(clk), .axi_aresetn(rstn), .bus(bus2), .icap_avail(avail),
    .icap_busy(busy2), .icap_csib(csib2), .icap_rdwrb(rdwrb2),
    .icap_i(ii2), .icap_o(io2)
  );

  function automatic logic [31:0] rev8(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++)
        r[8*b + k] = w[8*b + (7 - k)];
    return r;
  endfunction

  // ICAP model: valid data only in the last cycle of the read window
  always @(posedge clk) rdcnt8 <= (!csib8 && rdwrb8) ? rdcnt8 + 1 : 0;
  always @(posedge clk) rdcnt2 <= (!csib2 && rdwrb2) ? rdcnt2 + 1 : 0;
  assign io8 = (!csib8 && rdwrb8 && rdcnt8 == 7) ? rev8(mval) : 32'h5A5A_A5A5;
  assign io2 = (!csib2 && rdwrb2 && rdcnt2 == 1) ? rev8(mval) : 32'h5A5A_A5A5;

  logic        o_req_ready, o_rsp_valid, o_busy, o_csib, o_rdwrb;
  logic [31:0] o_rsp_data, o_i;
  assign o_req_ready = dsel ? bus2.req_ready : bus8.req_ready;
  assign o_rsp_valid = dsel ? bus2.rsp_valid : bus8.rsp_valid;
  assign o_rsp_data  = dsel ? bus2.rsp_data  : bus8.rsp_data;
  assign o_busy      = dsel ? busy2  : busy8;
  assign o_csib      = dsel ? csib2  : csib8;
  assign o_rdwrb     = dsel ? rdwrb2 : rdwrb8;
  assign o_i         = dsel ? ii2    : ii8;

  // Expected pin state in cycle c after accept (c = 1 is the first word)
  function automatic void exp_cycle(input int c, input int rw, input logic [4:0] r,
                                    output logic ecs, output logic erd, output logic ebusy,
                                    output logic echk, output logic [31:0] eiw,
                                    output logic evld);
    logic [31:0] hdr [7];
    logic [31:0] ds  [4];
    hdr[0] = 32'hFFFF_FFFF; hdr[1] = 32'hAA99_5566; hdr[2] = 32'h2000_0000;
    hdr[3] = 32'h2000_0000; hdr[4] = 32'h2800_0000 | (32'(r) << 13) | 32'd1;
    hdr[5] = 32'h2000_0000; hdr[6] = 32'h2000_0000;
    ds[0] = 32'h3000_8001; ds[1] = 32'h0000_000D; ds[2] = 32'h2000_0000; ds[3] = 32'h2000_0000;
    ecs = 1'b1; erd = 1'b0; ebusy = 1'b1; echk = 1'b0; eiw = '0; evld = 1'b0;
    if (c <= 7) begin
      ecs = 1'b0; echk = 1'b1; eiw = rev8(hdr[c-1]);
    end else if (c == 8) begin
      ecs = 1'b1;
    end else if (c == 9) begin
      erd = 1'b1;
    end else if (c <= 9 + rw) begin
      ecs = 1'b0; erd = 1'b1;
    end else if (c == 10 + rw) begin
      erd = 1'b1;
    end else if (c == 11 + rw) begin
      erd = 1'b0;
    end else if (c <= 15 + rw) begin
      ecs = 1'b0; echk = 1'b1; eiw = rev8(ds[c-12-rw]);
    end else begin
      ebusy = 1'b0; evld = 1'b1;
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full read; hold = cycles rsp_ready stays low, pend = second request waiting,
  // drop = AVAIL toggled low in the middle of the sequence
  task automatic run_read(input logic [4:0] r, input logic [31:0] val, input int rw,
                          input int hold, input bit pend, input bit drop);
    int n;
    int busy_n;
    int last;
    logic ecs, erd, ebusy, echk, evld;
    logic [31:0] eiw;
    logic [31:0] d;
    last = 16 + rw;
    req_reg = r; mval = val; req_valid = 1'b1; rsp_ready = (hold == 0);
    exp_q.push_back(val);
    n = 0;
    while (!o_req_ready && n < 40) begin tick; n++; end
    n_cmp++;
    if (o_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_timeout reg=%h: req_ready=%b required 1", r, o_req_ready);
      req_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    tick;
    req_valid = 1'b0;
    req_reg = ~r;
    busy_n = 0;
    for (int c = 1; c <= last; c++) begin
      if (drop && c == 5)  avail = 1'b0;
      if (drop && c == 14) avail = 1'b1;
      exp_cycle(c, rw, r, ecs, erd, ebusy, echk, eiw, evld);
      n_cmp++;
      if (o_csib !== ecs) begin n_bad++; $display("FAIL csib c=%0d: got %b required %b", c, o_csib, ecs); end
      n_cmp++;
      if (o_rdwrb !== erd) begin n_bad++; $display("FAIL rdwrb c=%0d: got %b required %b", c, o_rdwrb, erd); end
      n_cmp++;
      if (o_busy !== ebusy) begin n_bad++; $display("FAIL busy c=%0d: got %b required %b", c, o_busy, ebusy); end
      n_cmp++;
      if (o_rsp_valid !== evld) begin n_bad++; $display("FAIL rsp_valid c=%0d: got %b required %b", c, o_rsp_valid, evld); end
      if (echk) begin
        n_cmp++;
        if (o_i !== eiw) begin n_bad++; $display("FAIL icap_i c=%0d: got %h required %h", c, o_i, eiw); end
      end
      if (o_busy === 1'b1) busy_n++;
      if (c < last) tick;
    end
    d = exp_q.pop_front();
    n_cmp++;
    if (o_rsp_data !== d) begin n_bad++; $display("FAIL rsp_data: got %h required %h", o_rsp_data, d); end
    n_cmp++;
    if (busy_n != 15 + rw) begin n_bad++; $display("FAIL busy_len: got %0d required %0d", busy_n, 15 + rw); end
    n_cmp++;
    if (o_req_ready !== 1'b0) begin n_bad++; $display("FAIL ready_in_resp: got %b required 0", o_req_ready); end
    for (int h = 0; h < hold; h++) begin
      req_valid = pend;
      tick;
      n_cmp++;
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== d) begin
        n_bad++; $display("FAIL hold h=%0d: valid=%b data=%h required 1/%h", h, o_rsp_valid, o_rsp_data, d);
      end
      n_cmp++;
      if (o_req_ready !== 1'b0 || o_csib !== 1'b1 || o_busy !== 1'b0) begin
        n_bad++; $display("FAIL hold_idle h=%0d: ready=%b csib=%b busy=%b required 0/1/0", h, o_req_ready, o_csib, o_busy);
      end
    end
    rsp_ready = 1'b1;
    tick;
    n_cmp++;
    if (o_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rsp_len: valid=%b required 0", o_rsp_valid); end
    n_cmp++;
    if (o_rsp_data !== d) begin n_bad++; $display("FAIL rsp_keep: got %h required %h", o_rsp_data, d); end
    n_cmp++;
    if (o_req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after: got %b required 1", o_req_ready); end
  endtask

  task automatic test_reset;
    rstn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; avail = 1'b1; dsel = 1'b0;
    req_reg = '0; mval = '0;
    tick; tick;
    n_cmp++;
    if (csib8 !== 1'b1 || rdwrb8 !== 1'b0 || ii8 !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL reset_pins: csib=%b rdwrb=%b i=%h required 1/0/ffffffff", csib8, rdwrb8, ii8);
    end
    n_cmp++;
    if (bus8.rsp_valid !== 1'b0 || bus8.rsp_data !== 32'h0 || busy8 !== 1'b0) begin
      n_bad++; $display("FAIL reset_rsp: valid=%b data=%h busy=%b required 0/0/0", bus8.rsp_valid, bus8.rsp_data, busy8);
    end
    n_cmp++;
    if (bus8.req_ready !== 1'b0 || bus2.req_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready: got %b/%b required 0/0", bus8.req_ready, bus2.req_ready);
    end
    rstn = 1'b1;
    tick;
    n_cmp++;
    if (bus8.req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_post_reset: got %b required 1", bus8.req_ready); end
  endtask

  task automatic test_idcode;
    run_read(5'h0C, 32'h04B7_9093, 8, 0, 1'b0, 1'b0);
  endtask

  task automatic test_desync;
    run_read(5'h16, 32'h8000_0001, 8, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_read(5'h07, 32'hCAFE_F00D, 8, 10, 1'b1, 1'b0);
    run_read(5'h07, 32'h1234_5678, 8, 0, 1'b0, 1'b0);
  endtask

  task automatic test_avail;
    avail = 1'b0; req_valid = 1'b1; req_reg = 5'h0C;
    for (int k = 0; k < 5; k++) begin
      tick;
      n_cmp++;
      if (o_req_ready !== 1'b0 || o_csib !== 1'b1 || o_busy !== 1'b0) begin
        n_bad++; $display("FAIL avail_gate k=%0d: ready=%b csib=%b busy=%b required 0/1/0", k, o_req_ready, o_csib, o_busy);
      end
    end
    avail = 1'b1;
    #1;
    n_cmp++;
    if (o_req_ready !== 1'b1) begin n_bad++; $display("FAIL avail_rise: ready=%b required 1", o_req_ready); end
    run_read(5'h0C, 32'h0FED_CBA9, 8, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    int n;
    req_reg = 5'h0C; mval = 32'h04B7_9093; req_valid = 1'b1;
    n = 0;
    while (!o_req_ready && n < 40) begin tick; n++; end
    tick;
    req_valid = 1'b0;
    for (int c = 2; c <= 12; c++) tick;
    n_cmp++;
    if (o_csib !== 1'b0 || o_rdwrb !== 1'b1) begin
      n_bad++; $display("FAIL mid_rdwait: csib=%b rdwrb=%b required 0/1", o_csib, o_rdwrb);
    end
    rstn = 1'b0;
    tick;
    n_cmp++;
    if (o_csib !== 1'b1 || o_rdwrb !== 1'b0 || o_busy !== 1'b0 || o_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset: csib=%b rdwrb=%b busy=%b valid=%b required 1/0/0/0", o_csib, o_rdwrb, o_busy, o_rsp_valid);
    end
    n_cmp++;
    if (o_rsp_data !== 32'h0 || o_i !== 32'hFFFF_FFFF || o_req_ready !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_data: data=%h i=%h ready=%b required 0/ffffffff/0", o_rsp_data, o_i, o_req_ready);
    end
    rstn = 1'b1;
    tick;
    run_read(5'h10, 32'h0040_0000, 8, 0, 1'b0, 1'b0);
  endtask

  task automatic test_rw2;
    dsel = 1'b1;
    #1;
    run_read(5'h0C, 32'h1372_3093, 2, 0, 1'b0, 1'b0);
    run_read(5'h0E, 32'hA5C3_0F96, 2, 3, 1'b0, 1'b0);
    dsel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_idcode;
    test_desync;
    test_back_to_back;
    test_avail;
    test_reset_mid;
    test_rw2;
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left: %0d entries required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
